// File: rtl/instr_fetch.sv
// Fetch stage for the 4-bit CPU: loadable program store, program counter and internal
// resolution of jump / jump-if-zero / halt; everything else is issued to control via valid/ready.
module instr_fetch #(
  parameter int unsigned     ADDR_W  = 4,
  parameter int unsigned     OP_W    = 4,
  parameter int unsigned     ARG_W   = 4,
  parameter logic [OP_W-1:0] JMP_OP  = 4'hE,
  parameter logic [OP_W-1:0] JZ_OP   = 4'hD,
  parameter logic [OP_W-1:0] HALT_OP = 4'hF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  load_en,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic [OP_W+ARG_W-1:0] load_data,
  input  logic                  zero_flag,
  input  logic                  ready,
  output logic                  valid,
  output logic [OP_W-1:0]       memoria,
  output logic [ARG_W-1:0]      entrada,
  output logic [ADDR_W-1:0]     contador,
  output logic                  halted,
  output logic                  busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned IW    = OP_W + ARG_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [IW-1:0]     r_ir;
  logic [IW-1:0]     r_mem [DEPTH];

  logic [IW-1:0]     w_fetch_word;
  logic [OP_W-1:0]   w_fetch_op;
  logic [OP_W-1:0]   w_ir_op;
  logic [ARG_W-1:0]  w_ir_arg;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_store_open;

  function automatic logic is_internal(input logic [OP_W-1:0] op);
    return (op == JMP_OP) || (op == JZ_OP) || (op == HALT_OP);
  endfunction

  assign w_fetch_word = r_mem[r_pc];
  assign w_fetch_op   = w_fetch_word[IW-1:ARG_W];
  assign w_ir_op      = r_ir[IW-1:ARG_W];
  assign w_ir_arg     = r_ir[ARG_W-1:0];
  assign w_pc_inc     = r_pc + ADDR_W'(1);
  assign w_store_open = (r_state == S_IDLE) || (r_state == S_HALT);
  assign busy         = (r_state == S_FETCH) || (r_state == S_ISSUE);

  // Program store: writable only while nothing is executing, never reset.
  always_ff @(posedge clock) begin
    if (load_en && w_store_open) begin
      r_mem[load_addr] <= load_data;
    end
  end

  // Sequencer: valid is raised on the FETCH edge so it is already stable on entering ISSUE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_pc     <= {ADDR_W{1'b0}};
      r_ir     <= {IW{1'b0}};
      valid    <= 1'b0;
      memoria  <= {OP_W{1'b0}};
      entrada  <= {ARG_W{1'b0}};
      contador <= {ADDR_W{1'b0}};
      halted   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc    <= {ADDR_W{1'b0}};
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_ir     <= w_fetch_word;
          contador <= r_pc;
          r_state  <= S_ISSUE;
          if (!is_internal(w_fetch_op)) begin
            valid   <= 1'b1;
            memoria <= w_fetch_op;
            entrada <= w_fetch_word[ARG_W-1:0];
          end
        end
        S_ISSUE: begin
          if (w_ir_op == HALT_OP) begin
            halted  <= 1'b1;
            r_state <= S_HALT;
          end else if (w_ir_op == JMP_OP) begin
            r_pc    <= ADDR_W'(w_ir_arg);
            r_state <= S_FETCH;
          end else if (w_ir_op == JZ_OP) begin
            r_pc    <= zero_flag ? ADDR_W'(w_ir_arg) : w_pc_inc;
            r_state <= S_FETCH;
          end else if (ready) begin
            r_pc    <= w_pc_inc;
            valid   <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        S_HALT: begin
          if (start) begin
            r_pc    <= {ADDR_W{1'b0}};
            halted  <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
          valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed programs push expected issues; a negedge
// monitor pops and compares every accepted (valid & ready) instruction.
module tb_instr_fetch;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       zero_flag;
  logic       ready;
  logic       valid;
  logic [3:0] memoria;
  logic [3:0] entrada;
  logic [3:0] contador;
  logic       halted;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] sb[$];

  instr_fetch dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .zero_flag(zero_flag),
    .ready    (ready),
    .valid    (valid),
    .memoria  (memoria),
    .entrada  (entrada),
    .contador (contador),
    .halted   (halted),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clock) begin
    logic [11:0] exp_item;
    if (reset_n && valid && ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_issue: got op=%h arg=%h addr=%h, expected nothing", memoria, entrada, contador);
      end else begin
        exp_item = sb.pop_front();
        if ({memoria, entrada, contador} !== exp_item) begin
          n_fail++;
          $display("FAIL issue: got op=%h arg=%h addr=%h, expected op=%h arg=%h addr=%h",
                   memoria, entrada, contador, exp_item[11:8], exp_item[7:4], exp_item[3:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!valid && n < 50) begin
      tick();
      n++;
    end
    check({name, "_valid_seen"}, 32'(valid), 32'd1);
  endtask

  task automatic wait_halted(input string name);
    int n;
    n = 0;
    while (!halted && n < 100) begin
      tick();
      n++;
    end
    check({name, "_halted"}, 32'(halted), 32'd1);
    check({name, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [5:0] exp_valid_seq;
    logic [5:0] exp_halt_seq;
    reset_n   = 1'b0;
    start     = 1'b0;
    load_en   = 1'b0;
    load_addr = 4'h0;
    load_data = 8'h00;
    zero_flag = 1'b0;
    ready     = 1'b0;
    #12;
    check("reset_outputs", 32'({valid, memoria, entrada, contador, halted, busy}), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Basic program, cycle-exact handshake timing.
    load(4'h0, 8'h13);
    load(4'h1, 8'h2A);
    load(4'h2, 8'hF0);
    check("idle_not_busy", 32'(busy), 32'd0);
    sb.push_back(12'h130);
    sb.push_back(12'h2A1);
    ready = 1'b1;
    pulse_start();
    exp_valid_seq = 6'b000101;
    exp_halt_seq  = 6'b100000;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t1_valid_c%0d", i), 32'(valid), 32'(exp_valid_seq[i]));
      check($sformatf("t1_halted_c%0d", i), 32'(halted), 32'(exp_halt_seq[i]));
    end
    check("t1_busy_after_halt", 32'(busy), 32'd0);
    wait_halted("t1");
    repeat (3) tick();
    check("t1_no_valid_in_halt", 32'(valid), 32'd0);

    // Back-pressure: outputs hold while ready is low.
    ready = 1'b0;
    sb.push_back(12'h130);
    sb.push_back(12'h2A1);
    pulse_start();
    wait_valid("t2");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_hold_c%0d", i), 32'({valid, memoria, entrada, contador}), 32'({1'b1, 4'h1, 4'h3, 4'h0}));
      tick();
    end
    ready = 1'b1;
    wait_halted("t2");

    // Unconditional jump skips address 0.
    load(4'h0, 8'hE5);
    load(4'h5, 8'h17);
    load(4'h6, 8'hF0);
    sb.push_back(12'h175);
    pulse_start();
    wait_halted("t3");

    // Jump-if-zero, both outcomes.
    load(4'h0, 8'hD4);
    load(4'h4, 8'h54);
    load(4'h5, 8'hF0);
    load(4'h1, 8'h61);
    load(4'h2, 8'hF0);
    zero_flag = 1'b1;
    sb.push_back(12'h544);
    pulse_start();
    wait_halted("t4_zf1");
    zero_flag = 1'b0;
    sb.push_back(12'h611);
    pulse_start();
    wait_halted("t4_zf0");

    // PC wraps from 15 to 0.
    load(4'h0, 8'hDF);
    load(4'hF, 8'h31);
    load(4'h1, 8'hF0);
    zero_flag = 1'b1;
    sb.push_back(12'h31F);
    pulse_start();
    wait_valid("t5");
    zero_flag = 1'b0;
    wait_halted("t5");
    check("t5_last_fetch_addr", 32'(contador), 32'h1);

    // Store writes are ignored while executing.
    load(4'h0, 8'h13);
    load(4'h1, 8'h2A);
    load(4'h2, 8'hF0);
    ready = 1'b0;
    sb.push_back(12'h130);
    sb.push_back(12'h2A1);
    pulse_start();
    wait_valid("t6");
    load(4'h1, 8'h77);
    ready = 1'b1;
    wait_halted("t6");

    // Asynchronous reset while an instruction is pending.
    ready = 1'b0;
    pulse_start();
    wait_valid("t7");
    check("t7_pending_addr", 32'(contador), 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_reset_outputs", 32'({valid, contador, halted, busy}), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("t7_idle_after_reset", 32'({valid, busy}), 32'd0);

    // Program retained across reset.
    ready = 1'b1;
    sb.push_back(12'h130);
    sb.push_back(12'h2A1);
    pulse_start();
    wait_halted("t8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
